// File: rtl/cnn_frame_sequencer.sv
// Frame scheduler: streams images from a pixel ROM into the CNN, scores each decision against a label ROM.
// Optional macro CYCLE_STATS_EN enables the per-image cycle statistics outputs (tied to 0 otherwise).
module cnn_frame_sequencer #(
  parameter int unsigned PIX_PER_IMG = 784,
  parameter int unsigned NUM_IMG     = 1000,
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned IMG_W       = 10,
  parameter int unsigned TIMEOUT     = 65535,
  parameter int unsigned GAP_CYC     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              pix_rd_en,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [7:0]        pix_rdata,
  output logic [IMG_W-1:0]  lbl_addr,
  input  logic [3:0]        lbl_rdata,
  output logic [7:0]        cnn_data,
  output logic              cnn_valid,
  input  logic              cnn_busy,
  input  logic [3:0]        cnn_decision,
  input  logic              cnn_valid_out,
  output logic              res_valid,
  output logic [3:0]        res_decision,
  output logic              res_pass,
  output logic [IMG_W-1:0]  img_index,
  output logic [IMG_W:0]    correct_count,
  output logic [31:0]       total_cycles,
  output logic              run_busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       img_cycles,
  output logic [31:0]       max_img_cycles
);

  typedef enum logic [2:0] {IDLE, STREAM, WAIT_RES, GAP, DONE} state_t;
  state_t state, state_nx;

  logic [31:0] pix_cnt, wait_cnt, gap_cnt;
  logic start_ok, last_pix, got_res, timed_out, res_evt, last_img, gap_done, dec_match, stray_res;

  assign start_ok  = start && (state == IDLE || state == DONE);
  assign last_pix  = (state == STREAM) && (pix_cnt == PIX_PER_IMG - 1);
  assign got_res   = (state == WAIT_RES) && cnn_valid_out;
  // A decision arriving on the expiry cycle takes priority over the timeout
  assign timed_out = (state == WAIT_RES) && !cnn_valid_out && (wait_cnt + 32'd1 >= TIMEOUT);
  assign res_evt   = got_res || timed_out;
  assign last_img  = (img_index == IMG_W'(NUM_IMG - 1));
  assign gap_done  = (state == GAP) && !cnn_busy && (gap_cnt + 32'd1 >= GAP_CYC);
  assign dec_match = (cnn_decision == lbl_rdata);
  assign stray_res = cnn_valid_out && (state == STREAM || state == GAP);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start)    state_nx = STREAM;
      STREAM:     if (last_pix) state_nx = WAIT_RES;
      WAIT_RES:   if (res_evt)  state_nx = last_img ? DONE : GAP;
      GAP:        if (gap_done) state_nx = STREAM;
      default:                  state_nx = IDLE;
    endcase
  end

  // The ROM's read register is the data stage, so cnn_data is aligned with the delayed strobe
  always_comb begin
    pix_rd_en = (state == STREAM);
    run_busy  = (state == STREAM) || (state == WAIT_RES) || (state == GAP);
    done      = (state == DONE);
    lbl_addr  = img_index;
    cnn_data  = cnn_valid ? pix_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_addr      <= '0;
      pix_cnt       <= '0;
      wait_cnt      <= '0;
      gap_cnt       <= '0;
      img_index     <= '0;
      cnn_valid     <= 1'b0;
      res_valid     <= 1'b0;
      res_decision  <= '0;
      res_pass      <= 1'b0;
      correct_count <= '0;
      total_cycles  <= '0;
      err           <= 1'b0;
    end else begin
      cnn_valid <= pix_rd_en;
      res_valid <= res_evt;
      pix_cnt   <= (state == STREAM && !last_pix) ? pix_cnt + 32'd1 : '0;
      wait_cnt  <= (state == WAIT_RES && !res_evt) ? wait_cnt + 32'd1 : '0;
      gap_cnt   <= (state == GAP && !cnn_busy && !gap_done) ? gap_cnt + 32'd1 : '0;

      if (start_ok)       pix_addr <= '0;
      else if (pix_rd_en) pix_addr <= pix_addr + ADDR_W'(1);

      if (start_ok)      img_index <= '0;
      else if (gap_done) img_index <= img_index + IMG_W'(1);

      if (got_res) begin
        res_decision <= cnn_decision;
        res_pass     <= dec_match;
      end else if (timed_out) begin
        res_decision <= 4'hF;
        res_pass     <= 1'b0;
      end

      if (start_ok)                  correct_count <= '0;
      else if (got_res && dec_match) correct_count <= correct_count + (IMG_W+1)'(1);

      if (start_ok)                          total_cycles <= '0;
      else if (run_busy && total_cycles != '1) total_cycles <= total_cycles + 32'd1;

      if (start_ok)                    err <= 1'b0;
      else if (timed_out || stray_res) err <= 1'b1;
    end
  end

`ifdef CYCLE_STATS_EN
  logic [31:0] img_cnt, img_len;
  assign img_len = img_cnt + 32'd1;

  always_ff @(posedge clk) begin
    if (!rst_n || start_ok) begin
      img_cnt        <= '0;
      img_cycles     <= '0;
      max_img_cycles <= '0;
    end else begin
      if (gap_done)      img_cnt <= '0;
      else if (run_busy) img_cnt <= img_len;
      if (res_evt) begin
        img_cycles <= img_len;
        if (img_len > max_img_cycles) max_img_cycles <= img_len;
      end
    end
  end
`else
  assign img_cycles     = '0;
  assign max_img_cycles = '0;
`endif

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Directed bench for cnn_frame_sequencer: table of 2-image runs plus gap, stray-result and mid-run reset sequences.
module tb_cnn_frame_sequencer;
  localparam int PIX = 784;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pix_rd_en;
  logic [19:0] pix_addr;
  logic [7:0]  pix_rdata = 8'h00;
  logic [9:0]  lbl_addr;
  logic [3:0]  lbl_rdata = 4'h0;
  logic [7:0]  cnn_data;
  logic        cnn_valid;
  logic        busy = 1'b0;
  logic [3:0]  dec_in = 4'h0;
  logic        vo = 1'b0;
  logic        res_valid;
  logic [3:0]  res_decision;
  logic        res_pass;
  logic [9:0]  img_index;
  logic [10:0] correct_count;
  logic [31:0] total_cycles;
  logic        run_busy, done, err;
  logic [31:0] img_cycles, max_img_cycles;

  cnn_frame_sequencer #(.PIX_PER_IMG(PIX), .NUM_IMG(2), .TIMEOUT(TMO), .GAP_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pix_rd_en(pix_rd_en), .pix_addr(pix_addr), .pix_rdata(pix_rdata),
    .lbl_addr(lbl_addr), .lbl_rdata(lbl_rdata),
    .cnn_data(cnn_data), .cnn_valid(cnn_valid), .cnn_busy(busy),
    .cnn_decision(dec_in), .cnn_valid_out(vo),
    .res_valid(res_valid), .res_decision(res_decision), .res_pass(res_pass),
    .img_index(img_index), .correct_count(correct_count), .total_cycles(total_cycles),
    .run_busy(run_busy), .done(done), .err(err),
    .img_cycles(img_cycles), .max_img_cycles(max_img_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix_f(input int a);
    logic [31:0] v;
    v = a;
    return v[7:0] ^ v[15:8] ^ 8'h5A;
  endfunction

  logic [3:0] lbl0 = 4'h0, lbl1 = 4'h0;
  always @(posedge clk) begin
    if (pix_rd_en) pix_rdata <= pix_f(int'(pix_addr));
    lbl_rdata <= (lbl_addr == 10'd0) ? lbl0 : lbl1;
  end

  typedef struct {
    logic [3:0] lbl0, lbl1, dec0, dec1;
    int         lat0, lat1;          // 0: model never answers
    logic [3:0] xdec0, xdec1;
    logic       xpass0, xpass1;
    int         xcorrect;
    logic       xerr;
  } scen_t;
  scen_t tbl [5];

  int n_chk = 0, n_err = 0;
  int exp_rd, last_rd, rd_err, streak, px_addr, data_err, dbl;
  int mdl_cnt, mdl_img, mdl_idx;
  bit prev_rv;
  int bursts[$];
  logic [3:0] res_dec[$];
  bit res_ps[$];
  logic [3:0] cur_dec [2];
  int cur_lat [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_trk();
    exp_rd = 0; last_rd = -1; rd_err = 0; streak = 0; px_addr = 0; data_err = 0; dbl = 0;
    mdl_cnt = 0; mdl_img = 0; mdl_idx = 0; prev_rv = 1'b0;
    bursts.delete(); res_dec.delete(); res_ps.delete();
  endtask

  // One cycle: CNN model answers a fixed latency after the last pixel, monitors record the stream.
  task automatic step();
    @(negedge clk);
    vo = 1'b0;
    if (mdl_cnt > 0) begin
      mdl_cnt--;
      if (mdl_cnt == 0) begin
        vo = 1'b1;
        dec_in = cur_dec[mdl_idx];
      end
    end
    if (pix_rd_en) begin
      if (int'(pix_addr) != exp_rd) rd_err++;
      last_rd = int'(pix_addr);
      exp_rd++;
    end
    if (cnn_valid) begin
      streak++;
      if (cnn_data !== pix_f(px_addr)) data_err++;
      px_addr++;
      if (streak == PIX) begin
        if (cur_lat[mdl_img] != 0) begin
          mdl_cnt = cur_lat[mdl_img];
          mdl_idx = mdl_img;
        end
        mdl_img = 1 - mdl_img;
      end
    end else if (streak != 0) begin
      bursts.push_back(streak);
      streak = 0;
    end
    if (res_valid) begin
      if (prev_rv) dbl++;
      res_dec.push_back(res_decision);
      res_ps.push_back(res_pass);
    end
    prev_rv = res_valid;
  endtask

  task automatic do_start();
    clear_trk();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int limit);
    int n = 0;
    while (!done && n < limit) begin
      step();
      n++;
    end
    chk("done_reached", done, 1);
  endtask

  task automatic wait_res(input int cnt, input int limit);
    int n = 0;
    while (res_dec.size() < cnt && n < limit) begin
      step();
      n++;
    end
    chk("res_seen", res_dec.size(), cnt);
  endtask

  task automatic set_cfg(input logic [3:0] l0, l1, d0, d1, input int t0, t1);
    lbl0 = l0; lbl1 = l1;
    cur_dec[0] = d0; cur_dec[1] = d1;
    cur_lat[0] = t0; cur_lat[1] = t1;
  endtask

  task automatic chk_zero();
    chk("z_rd_en", pix_rd_en, 0);
    chk("z_pix_addr", pix_addr, 0);
    chk("z_cnn_valid", cnn_valid, 0);
    chk("z_cnn_data", cnn_data, 0);
    chk("z_res_valid", res_valid, 0);
    chk("z_res_dec", res_decision, 0);
    chk("z_res_pass", res_pass, 0);
    chk("z_img_index", img_index, 0);
    chk("z_correct", correct_count, 0);
    chk("z_total", total_cycles, 0);
    chk("z_run_busy", run_busy, 0);
    chk("z_done", done, 0);
    chk("z_err", err, 0);
    chk("z_img_cycles", img_cycles, 0);
    chk("z_max_cycles", max_img_cycles, 0);
  endtask

  function automatic int wlen(input int lat);
    return (lat == 0) ? TMO : lat + 1;
  endfunction

  initial begin
    int w0, w1, k, n, held;
    tbl[0] = '{4'd2, 4'd9,  4'd2, 4'd9, 5,  5,  4'd2, 4'd9, 1'b1, 1'b1, 2, 1'b0};
    tbl[1] = '{4'd3, 4'd7,  4'd3, 4'd1, 5,  5,  4'd3, 4'd1, 1'b1, 1'b0, 1, 1'b0};
    tbl[2] = '{4'd4, 4'd6,  4'd0, 4'd0, 0,  0,  4'hF, 4'hF, 1'b0, 1'b0, 0, 1'b1};
    tbl[3] = '{4'd8, 4'd5,  4'd8, 4'd5, 99, 99, 4'd8, 4'd5, 1'b1, 1'b1, 2, 1'b0};
    tbl[4] = '{4'd1, 4'd15, 4'd1, 4'd0, 5,  0,  4'd1, 4'hF, 1'b1, 1'b0, 1, 1'b1};
    clear_trk();
    set_cfg(4'd0, 4'd0, 4'd0, 4'd0, 0, 0);

    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk_zero();

    for (int i = 0; i < 5; i++) begin
      set_cfg(tbl[i].lbl0, tbl[i].lbl1, tbl[i].dec0, tbl[i].dec1, tbl[i].lat0, tbl[i].lat1);
      do_start();
      chk("err_cleared", err, 0);
      chk("first_rd", {pix_rd_en, pix_addr}, {1'b1, 20'd0});
      run_to_done(4000);
      chk("res_count", res_dec.size(), 2);
      if (res_dec.size() == 2) begin
        chk("res_dec0", res_dec[0], tbl[i].xdec0);
        chk("res_dec1", res_dec[1], tbl[i].xdec1);
        chk("res_pass0", res_ps[0], tbl[i].xpass0);
        chk("res_pass1", res_ps[1], tbl[i].xpass1);
      end
      chk("correct_count", correct_count, tbl[i].xcorrect);
      chk("err", err, tbl[i].xerr);
      chk("run_busy_done", run_busy, 0);
      chk("img_index", img_index, 1);
      chk("bursts", (bursts.size() == 2) && (bursts[0] == PIX) && (bursts[1] == PIX), 1);
      chk("last_rd_addr", last_rd, 2 * PIX - 1);
      chk("rd_seq_err", rd_err, 0);
      chk("data_err", data_err, 0);
      chk("res_pulse_len", dbl, 0);
      w0 = wlen(tbl[i].lat0);
      w1 = wlen(tbl[i].lat1);
      chk("total_cycles", total_cycles, 2 * PIX + w0 + 2 + w1);
`ifdef CYCLE_STATS_EN
      chk("img_cycles", img_cycles, PIX + w1);
      chk("max_img_cycles", max_img_cycles, PIX + ((w0 > w1) ? w0 : w1));
`else
      chk("img_cycles", img_cycles, 0);
      chk("max_img_cycles", max_img_cycles, 0);
`endif
      held = int'(total_cycles);
      repeat (3) step();
      chk("hold_done", {done, res_valid, 20'(res_dec.size())}, {1'b1, 1'b0, 20'd2});
      chk("hold_total", total_cycles, held);
    end

    // Ignored start, stray result in STREAM, then busy held 50 cycles after the first result
    set_cfg(4'd2, 4'd9, 4'd2, 4'd9, 5, 5);
    do_start();
    n = 0;
    while (!(pix_rd_en && pix_addr == 20'd200) && n < 400) begin step(); n++; end
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_ignored", pix_addr, 201);
    dec_in = 4'hA;
    vo = 1'b1;
    step();
    chk("err_stray_vo", err, 1);
    chk("stray_not_recorded", res_dec.size(), 0);
    wait_res(1, 2000);
    busy = 1'b1;
    k = 0;
    while (!pix_rd_en && k < 200) begin
      step();
      k++;
      if (k == 50) busy = 1'b0;
    end
    busy = 1'b0;
    chk("gap_after_busy50", k, 52);
    run_to_done(2000);
    chk("busy_run_correct", correct_count, 2);
    chk("busy_run_err_sticky", err, 1);
    chk("busy_run_rd_seq", rd_err, 0);

    // Single-cycle busy glitch inside the gap restarts the count
    do_start();
    chk("err_cleared2", err, 0);
    wait_res(1, 2000);
    step();
    busy = 1'b1;
    step();
    busy = 1'b0;
    k = 2;
    while (!pix_rd_en && k < 50) begin step(); k++; end
    chk("gap_glitch_restart", k, 4);
    run_to_done(2000);
    chk("glitch_run_correct", correct_count, 2);

    // Reset for one cycle at pixel 400 of image 0, then a clean restart
    do_start();
    n = 0;
    while (!(pix_rd_en && pix_addr == 20'd400) && n < 600) begin step(); n++; end
    chk("reached_pix400", pix_addr, 400);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_zero();
    step();
    chk("idle_after_reset", {run_busy, pix_rd_en, cnn_valid}, 0);
    do_start();
    chk("restart_addr0", {pix_rd_en, pix_addr}, {1'b1, 20'd0});
    run_to_done(4000);
    chk("restart_correct", correct_count, 2);
    chk("restart_last_rd", last_rd, 2 * PIX - 1);
    chk("restart_rd_seq", rd_err, 0);
    chk("restart_bursts", (bursts.size() == 2) && (bursts[0] == PIX) && (bursts[1] == PIX), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
